// File: rtl/present_pkg.sv
// Shared constants and types for the PRESENT-80 encrypt sequencer.
// Contents: block/key widths, round count, sequencer state encoding,
// and the {plaintext,key} request payload.
package present_pkg;

    localparam int unsigned PRESENT_ROUNDS = 31;
    localparam int unsigned BLK_W          = 64;
    localparam int unsigned KEY_W          = 80;
    // Round counter wide enough for 0..31; the 31->0 wrap marks completion.
    localparam int unsigned RND_W          = $clog2(PRESENT_ROUNDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [BLK_W-1:0] pt;
    } enc_req_t;

endpackage

// File: rtl/PRESENT_ENCRYPT.sv
// Iterative PRESENT-80 encryption core, one round per clock.
// Ports:
//   clk   clock
//   load  loads idat/key and restarts the round counter at 1
//   idat  plaintext, key  80-bit key
//   odat  current state XOR current round key; holds the ciphertext
//         31 edges after the load edge (round counter wraps to 0)
module PRESENT_ENCRYPT (
    output logic [63:0] odat,
    input  logic [63:0] idat,
    input  logic [79:0] key,
    input  logic        load,
    input  logic        clk
);

    logic [63:0] dat_q;
    logic [79:0] kreg_q;
    logic [4:0]  round_q;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
            4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
            4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
            4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] round_fn(input logic [63:0] x);
        logic [63:0] s;
        logic [63:0] p;
        for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox4(x[4*n +: 4]);
        // Bit permutation: bit i moves to i*16 mod 63, bit 63 stays.
        p = '0;
        for (int i = 0; i < 63; i++) p[(i*16) % 63] = s[i];
        p[63] = s[63];
        return p;
    endfunction

    function automatic logic [79:0] key_fn(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox4(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (load) begin
            dat_q   <= idat;
            kreg_q  <= key;
            round_q <= 5'd1;
        end else begin
            dat_q   <= round_fn(dat_q ^ kreg_q[79:16]);
            kreg_q  <= key_fn(kreg_q, round_q);
            round_q <= round_q + 5'd1;
        end
    end

    assign odat = dat_q ^ kreg_q[79:16];

endmodule

// File: rtl/present_ct_fifo.sv
// Synchronous first-word-fall-through FIFO for ciphertext results.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   push, push_data  write strobe and data (ignored when full without a pop)
//   pop           read strobe (ignored when empty)
//   head          data at FIFO head (don't-care when empty)
//   valid         FIFO not empty
//   count         number of stored entries
module present_ct_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_eff;
    logic             push_eff;

    assign pop_eff  = pop && (count_q != CNT_W'(0));
    assign push_eff = push && ((count_q != CNT_W'(DEPTH)) || pop_eff);

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_eff) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; contents are only visible when count is non-zero.
    always_ff @(posedge clk) begin
        if (push_eff) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign valid = (count_q != CNT_W'(0));
    assign count = count_q;

endmodule

// File: rtl/present_enc_sequencer.sv
// Feeds {plaintext,key} blocks into a PRESENT-80 core, counts its rounds,
// and queues the ciphertexts in a small FWFT FIFO.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready, in_pt, in_key   block input handshake
//   core_idat, core_key, core_load     registered drive to the core
//   core_odat                  core output
//   out_valid/out_ready, out_ct        result handshake (FIFO head)
//   busy                       block in flight
//   blk_cnt                    completed blocks, wraps
module present_enc_sequencer
    import present_pkg::*;
#(
    parameter int unsigned OUT_DEPTH = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_pt,
    input  logic [KEY_W-1:0] in_key,
    output logic [BLK_W-1:0] core_idat,
    output logic [KEY_W-1:0] core_key,
    output logic             core_load,
    input  logic [BLK_W-1:0] core_odat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_ct,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt
);

    localparam int unsigned FC_W = $clog2(OUT_DEPTH + 1);

    seq_state_e       state_q;
    logic [RND_W-1:0] cnt_q;
    logic             core_load_q;
    logic [CNT_W-1:0] blk_cnt_q;
    enc_req_t         req_q;
    logic [FC_W-1:0]  fifo_count;
    logic             accept;
    logic             capture;

    // A free slot is reserved at accept time, so the capture push never sees a full FIFO.
    assign in_ready = (state_q == ST_IDLE) && (fifo_count < FC_W'(OUT_DEPTH));
    assign accept   = in_valid && in_ready;
    // Counter mirrors the core's round register; its wrap to 0 means odat is final.
    assign capture  = (state_q == ST_RUN) && (cnt_q == RND_W'(0));

    // Sequencer FSM, round counter and completion counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            core_load_q <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            core_load_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        core_load_q <= 1'b1;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= RND_W'(1);
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + RND_W'(1);
                    if (capture) begin
                        blk_cnt_q <= blk_cnt_q + CNT_W'(1);
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Core operands are held across reset; only a fresh accept replaces them.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            req_q.pt  <= in_pt;
            req_q.key <= in_key;
        end
    end

    present_ct_fifo #(
        .WIDTH (BLK_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (core_odat),
        .pop       (out_ready),
        .head      (out_ct),
        .valid     (out_valid),
        .count     (fifo_count)
    );

    assign core_idat = req_q.pt;
    assign core_key  = req_q.key;
    assign core_load = core_load_q;
    assign busy      = (state_q != ST_IDLE);
    assign blk_cnt   = blk_cnt_q;

endmodule
